// File: rtl/axis_sample_unpacker_pkg.sv
// Shared definitions for the AXIS sample unpacker.
// Holds the default widths and a helper that sizes lane index registers.
package axis_sample_unpacker_pkg;

    localparam int unsigned DEF_AXIS_TDATA_WIDTH = 64;
    localparam int unsigned DEF_SAMPLE_WIDTH     = 16;
    localparam int unsigned DEF_DIVIDER_WIDTH    = 16;
    localparam int unsigned STS_COUNT_WIDTH      = 32;

    // Index width for n lanes, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sample_rate_tick.sv
// Programmable sample-rate tick generator.
// Ports:
//   aclk, aresetn : clock, async active-low reset
//   enable        : run control; low holds the counter at zero, no ticks
//   rate_div      : tick period minus one, in aclk cycles
//   tick          : combinational tick for the current cycle
module sample_rate_tick #(
    parameter int unsigned DIVIDER_WIDTH = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     enable,
    input  logic [DIVIDER_WIDTH-1:0] rate_div,
    output logic                     tick
);

    logic [DIVIDER_WIDTH-1:0] cnt_q;
    logic [DIVIDER_WIDTH-1:0] cnt_d;

    // The >= compare lets a lowered rate_div take effect on the next cycle.
    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q >= rate_div) begin
            tick  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIVIDER_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_sample_unpacker.sv
// Unpacks wide AXIS words into narrow samples, one per rate tick,
// least-significant lane first. AXIS_TDATA_WIDTH must be a multiple of
// SAMPLE_WIDTH.
// Ports:
//   aclk, aresetn        : clock, async active-low reset
//   enable               : run control
//   rate_div             : sample period minus one, in aclk cycles
//   underflow_clr        : single-cycle clear of the sticky underflow flag
//   s_axis_tdata/tvalid  : input word stream
//   s_axis_tready        : combinational ready (buffer empty or last lane now)
//   sample_data          : registered sample, held between strobes
//   sample_valid         : one-cycle strobe per emitted sample
//   underflow            : sticky, a tick found no word buffered
//   sample_count_sts     : samples emitted since reset, wrapping
module axis_sample_unpacker
    import axis_sample_unpacker_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = DEF_AXIS_TDATA_WIDTH,
    parameter int unsigned SAMPLE_WIDTH     = DEF_SAMPLE_WIDTH,
    parameter int unsigned DIVIDER_WIDTH    = DEF_DIVIDER_WIDTH
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        enable,
    input  logic [DIVIDER_WIDTH-1:0]    rate_div,
    input  logic                        underflow_clr,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [SAMPLE_WIDTH-1:0]     sample_data,
    output logic                        sample_valid,
    output logic                        underflow,
    output logic [STS_COUNT_WIDTH-1:0]  sample_count_sts
);

    localparam int unsigned LANES          = AXIS_TDATA_WIDTH / SAMPLE_WIDTH;
    localparam int unsigned LANE_IDX_WIDTH = idx_width(LANES);

    logic tick;

    logic [AXIS_TDATA_WIDTH-1:0] word_q,      word_d;
    logic                        held_q,      held_d;
    logic [LANE_IDX_WIDTH-1:0]   lane_idx_q,  lane_idx_d;
    logic [SAMPLE_WIDTH-1:0]     sample_q,    sample_d;
    logic                        valid_q,     valid_d;
    logic                        underflow_q, underflow_d;
    logic [STS_COUNT_WIDTH-1:0]  count_q,     count_d;

    logic [LANES-1:0][SAMPLE_WIDTH-1:0] lanes_c;
    logic                               emit_c;
    logic                               starve_c;
    logic                               last_lane_c;
    logic                               accept_c;

    sample_rate_tick #(
        .DIVIDER_WIDTH (DIVIDER_WIDTH)
    ) u_tick (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .enable   (enable),
        .rate_div (rate_div),
        .tick     (tick)
    );

    // Handshake decode; ready rises on the last-lane tick so words play back-to-back.
    always_comb begin
        lanes_c       = word_q;
        emit_c        = tick & held_q;
        starve_c      = tick & ~held_q;
        last_lane_c   = (lane_idx_q == LANE_IDX_WIDTH'(LANES - 1));
        s_axis_tready = ~held_q | (emit_c & last_lane_c);
        accept_c      = s_axis_tvalid & s_axis_tready;
    end

    // Buffer, lane sequencing and status next-state.
    always_comb begin
        word_d      = word_q;
        held_d      = held_q;
        lane_idx_d  = lane_idx_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        underflow_d = underflow_q;
        count_d     = count_q;

        if (emit_c) begin
            sample_d = lanes_c[lane_idx_q];
            valid_d  = 1'b1;
            count_d  = count_q + STS_COUNT_WIDTH'(1);
            if (last_lane_c) begin
                lane_idx_d = '0;
                held_d     = 1'b0;
            end else begin
                lane_idx_d = lane_idx_q + LANE_IDX_WIDTH'(1);
            end
        end

        // A word accepted now is first emitted on a later tick.
        if (accept_c) begin
            word_d     = s_axis_tdata;
            held_d     = 1'b1;
            lane_idx_d = '0;
        end

        // Set has priority over a coincident clear.
        if (starve_c) begin
            underflow_d = 1'b1;
        end else if (underflow_clr) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            word_q      <= '0;
            held_q      <= 1'b0;
            lane_idx_q  <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            underflow_q <= 1'b0;
            count_q     <= '0;
        end else begin
            word_q      <= word_d;
            held_q      <= held_d;
            lane_idx_q  <= lane_idx_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            underflow_q <= underflow_d;
            count_q     <= count_d;
        end
    end

    assign sample_data      = sample_q;
    assign sample_valid     = valid_q;
    assign underflow        = underflow_q;
    assign sample_count_sts = count_q;

endmodule

// File: tb/tb_axis_sample_unpacker.sv
// Self-checking bench for axis_sample_unpacker: accepted words are split into
// expected samples on a queue; a monitor pops one per strobe and compares.
module tb_axis_sample_unpacker;

    localparam int unsigned TDW   = 64;
    localparam int unsigned SW    = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned LANES = TDW / SW;

    logic           aclk          = 1'b0;
    logic           aresetn       = 1'b0;
    logic           enable        = 1'b0;
    logic [DW-1:0]  rate_div      = '0;
    logic           underflow_clr = 1'b0;
    logic [TDW-1:0] s_axis_tdata  = '0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tready;
    logic [SW-1:0]  sample_data;
    logic           sample_valid;
    logic           underflow;
    logic [31:0]    sample_count_sts;

    axis_sample_unpacker #(
        .AXIS_TDATA_WIDTH (TDW),
        .SAMPLE_WIDTH     (SW),
        .DIVIDER_WIDTH    (DW)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .enable           (enable),
        .rate_div         (rate_div),
        .underflow_clr    (underflow_clr),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .sample_data      (sample_data),
        .sample_valid     (sample_valid),
        .underflow        (underflow),
        .sample_count_sts (sample_count_sts)
    );

    always #5 aclk = ~aclk;

    int unsigned cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int          n_checks   = 0;
    int          n_fail     = 0;
    int unsigned mdl_count  = 0;
    logic [SW-1:0] exp_q[$];
    int unsigned   strobe_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_strobe(input string name, input int idx, input int unsigned exp_cyc);
        if (idx < strobe_cyc.size()) begin
            chk(name, 64'(strobe_cyc[idx]), 64'(exp_cyc));
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: strobe %0d missing, expected at cycle %0d", name, idx, exp_cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expected sample.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mdl_count = 0;
        end else begin
            #1;
            if (sample_valid === 1'b1) begin
                strobe_cyc.push_back(cyc);
                mdl_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got sample 0x%0h, expected no strobe", sample_data);
                end else begin
                    chk("sample_data", 64'(sample_data), 64'(exp_q.pop_front()));
                end
                chk("sample_count_sts", 64'(sample_count_sts), 64'(mdl_count));
            end
        end
    end

    // Offer a word; once ready is seen, its lanes become expected samples in order.
    task automatic send_word(input logic [TDW-1:0] w);
        bit done = 1'b0;
        s_axis_tdata  = w;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 400 && !done; n++) begin
            #1;
            if (s_axis_tready === 1'b1) begin
                for (int l = 0; l < LANES; l++) exp_q.push_back(w[l*SW +: SW]);
                done = 1'b1;
            end
            @(negedge aclk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = {$urandom, $urandom};
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no ready, expected acceptance within 400 cycles");
        end
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n = 0;
        while (strobe_cyc.size() < target && n < budget) begin
            @(negedge aclk);
            n++;
        end
        if (strobe_cyc.size() < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_timeout: got %0d strobes, expected %0d", strobe_cyc.size(), target);
        end
    endtask

    task automatic clear_underflow();
        underflow_clr = 1'b1;
        @(negedge aclk);
        underflow_clr = 1'b0;
    endtask

    initial begin
        int unsigned n0;
        int          gaps;

        // Reset state.
        repeat (2) @(negedge aclk);
        chk("rst_tready", 64'(s_axis_tready), 64'd1);
        chk("rst_sample_data", 64'(sample_data), 64'd0);
        chk("rst_sample_valid", 64'(sample_valid), 64'd0);
        chk("rst_underflow", 64'(underflow), 64'd0);
        chk("rst_count", 64'(sample_count_sts), 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);

        // Basic playback at rate_div=3, then underflow on the starved tick.
        rate_div = DW'(3);
        strobe_cyc.delete();
        send_word(64'h0004_0003_0002_0001);
        n0 = cyc;
        enable = 1'b1;
        wait_strobes(4, 100);
        chk_strobe("basic_first_strobe", 0, n0 + 4);
        chk_strobe("basic_strobe1", 1, n0 + 8);
        chk_strobe("basic_strobe2", 2, n0 + 12);
        chk_strobe("basic_strobe3", 3, n0 + 16);
        chk("basic_no_underflow_yet", 64'(underflow), 64'd0);
        repeat (4) @(negedge aclk);
        chk("basic_underflow", 64'(underflow), 64'd1);
        chk("basic_count", 64'(sample_count_sts), 64'd4);
        enable = 1'b0;
        clear_underflow();
        chk("basic_clr", 64'(underflow), 64'd0);

        // Full rate, continuous: 8 words, 32 gapless strobes.
        rate_div = DW'(0);
        strobe_cyc.delete();
        send_word({$urandom, $urandom});
        enable = 1'b1;
        for (int k = 0; k < 7; k++) send_word({$urandom, $urandom});
        wait_strobes(32, 200);
        chk("cont_underflow", 64'(underflow), 64'd0);
        enable = 1'b0;
        gaps = 0;
        for (int i = 1; i < strobe_cyc.size(); i++)
            if (strobe_cyc[i] != strobe_cyc[i-1] + 1) gaps++;
        chk("cont_gaps", 64'(gaps), 64'd0);
        chk("cont_strobes", 64'(strobe_cyc.size()), 64'd32);
        @(negedge aclk);
        chk("cont_underflow_after", 64'(underflow), 64'd0);

        // Starved source: underflow set, no strobe, clear loses to a coincident set.
        strobe_cyc.delete();
        send_word({$urandom, $urandom});
        enable = 1'b1;
        repeat (4) @(negedge aclk);
        chk("bp_strobes", 64'(strobe_cyc.size()), 64'd4);
        chk("bp_no_underflow", 64'(underflow), 64'd0);
        @(negedge aclk);
        chk("bp_underflow", 64'(underflow), 64'd1);
        chk("bp_missing_strobe", 64'(strobe_cyc.size()), 64'd4);
        clear_underflow();
        chk("bp_set_wins", 64'(underflow), 64'd1);
        for (int k = 0; k < 3; k++) begin
            send_word({$urandom, $urandom});
            repeat (2) @(negedge aclk);
        end
        wait_strobes(16, 100);
        enable = 1'b0;
        clear_underflow();
        chk("bp_clr", 64'(underflow), 64'd0);

        // Pause after lane 1, resume at lane 2.
        rate_div = DW'(2);
        strobe_cyc.delete();
        send_word({$urandom, $urandom});
        enable = 1'b1;
        wait_strobes(2, 50);
        enable = 1'b0;
        repeat (10) @(negedge aclk);
        chk("pause_no_strobe", 64'(strobe_cyc.size()), 64'd2);
        n0 = cyc;
        enable = 1'b1;
        wait_strobes(3, 50);
        chk_strobe("pause_resume", 2, n0 + 3);
        wait_strobes(4, 50);
        chk("pause_underflow", 64'(underflow), 64'd0);
        enable = 1'b0;
        @(negedge aclk);

        // Asynchronous reset mid-word discards the held word.
        rate_div = DW'(5);
        strobe_cyc.delete();
        send_word({$urandom, $urandom});
        enable = 1'b1;
        wait_strobes(1, 50);
        #2;
        aresetn = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_tready", 64'(s_axis_tready), 64'd1);
        chk("arst_sample_data", 64'(sample_data), 64'd0);
        chk("arst_sample_valid", 64'(sample_valid), 64'd0);
        chk("arst_count", 64'(sample_count_sts), 64'd0);
        chk("arst_underflow", 64'(underflow), 64'd0);
        @(negedge aclk);
        aresetn  = 1'b1;
        rate_div = DW'(0);
        strobe_cyc.delete();
        repeat (3) @(negedge aclk);
        chk("arst_word_dropped", 64'(strobe_cyc.size()), 64'd0);
        chk("arst_starved", 64'(underflow), 64'd1);
        enable = 1'b0;
        clear_underflow();

        // Lowering rate_div from 100 to 2 while cnt=50.
        rate_div = DW'(100);
        strobe_cyc.delete();
        send_word({$urandom, $urandom});
        n0 = cyc;
        enable = 1'b1;
        repeat (50) @(negedge aclk);
        rate_div = DW'(2);
        wait_strobes(4, 50);
        chk_strobe("rdiv_first", 0, n0 + 51);
        chk_strobe("rdiv_p1", 1, n0 + 54);
        chk_strobe("rdiv_p2", 2, n0 + 57);
        chk_strobe("rdiv_p3", 3, n0 + 60);
        enable = 1'b0;
        clear_underflow();

        // Random traffic: random rate and gaps, data order checked by the monitor.
        rate_div = DW'($urandom_range(0, 3));
        enable   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            send_word({$urandom, $urandom});
            repeat ($urandom_range(0, 5)) @(negedge aclk);
        end
        for (int n = 0; n < 2000 && exp_q.size() != 0; n++) @(negedge aclk);
        chk("rand_drained", 64'(exp_q.size()), 64'd0);
        enable = 1'b0;
        @(negedge aclk);
        chk("rand_final_count", 64'(sample_count_sts), 64'(mdl_count));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_sample_unpacker.md
# axis_sample_unpacker

Downstream stage of the RAM flow-control reader. Consumes the wide AXIS word stream replayed from DDR and emits one narrow sample per programmable rate tick, least-significant lane first. Feeds a DAC or gradient/RF output path at a fixed sample rate. Flags underflow when a tick arrives with no data buffered.

## Interface
Parameters:
- AXIS_TDATA_WIDTH, 64, input word width; must be an integer multiple of SAMPLE_WIDTH.
- SAMPLE_WIDTH, 16, output sample width.
- DIVIDER_WIDTH, 16, width of rate_div.

Ports:
- aclk  in  1  sole clock; all logic on rising edge.
- aresetn  in  1  reset, asynchronous assert, active-low.
- enable  in  1  run control; low holds the tick counter at 0 and suppresses output.
- rate_div  in  DIVIDER_WIDTH  sample period minus 1, in aclk cycles.
- underflow_clr  in  1  clears the underflow flag; synchronous, single-cycle pulse.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  packed samples, lane 0 in bits [SAMPLE_WIDTH-1:0].
- s_axis_tvalid  in  1  AXIS valid.
- s_axis_tready  out  1  AXIS ready.
- sample_data  out  SAMPLE_WIDTH  current sample, registered, held between strobes.
- sample_valid  out  1  one-cycle strobe per emitted sample.
- underflow  out  1  sticky: tick occurred with no word held.
- sample_count_sts  out  32  samples emitted since reset, wraps at 2^32.

## Operation
- LANES = AXIS_TDATA_WIDTH/SAMPLE_WIDTH. One word buffer (word_reg, held flag) plus lane index lane_idx, 0..LANES-1.
- Tick counter cnt: while enable=1, increment each cycle. Tick when cnt >= rate_div, and cnt returns to 0 on that cycle. Using >= makes a lowered rate_div take effect immediately. rate_div=0 gives a tick every cycle. While enable=0, cnt=0 and no ticks occur.
- On a tick with held=1:
  - Load lane lane_idx of word_reg into sample_data, assert sample_valid next cycle, increment sample_count_sts.
  - If lane_idx=LANES-1, set lane_idx to 0 and release the word.
  - Otherwise increment lane_idx.
- On a tick with held=0: set underflow; sample_data keeps its last value; sample_valid stays 0; count unchanged.
- s_axis_tready = !held || (tick && held && lane_idx==LANES-1). This is combinational, so the last lane and the next word's acceptance share a cycle and back-to-back words play out with no gap.
- Handshake (tvalid && tready): word_reg <= tdata, held <= 1, lane_idx <= 0. The new word is first emitted on the next tick, never in the same cycle it is accepted.
- If underflow_clr and an underflow tick occur in the same cycle, the set wins.
- enable falling mid-word: word_reg, held and lane_idx are kept. Playback resumes from the same lane when enable returns.
- tdata is ignored while tvalid=0. The block never drops or duplicates an accepted word.

## Timing
- Reset values: s_axis_tready=1 (empty buffer), sample_data=0, sample_valid=0, underflow=0, sample_count_sts=0, cnt=0, lane_idx=0, held=0.
- Tick at cycle t gives sample_data/sample_valid valid at t+1.
- After enable rises at cycle e, the first tick is at e+rate_div and the first strobe at e+rate_div+1.
- Strobe period is exactly rate_div+1 cycles while data is available.
- Word accepted at cycle a: its lane 0 is emitted on the first tick at or after a+1.

## Structure
- No shared-package content needed. LANES and LANE_IDX_WIDTH = max(1, $clog2(LANES)) are localparams in this module.
- One sub-module: sample_rate_tick, containing the cnt register, the >= compare and the enable gating, with output tick.
- The buffer, lane mux and status logic stay in the top module.

## Test plan
- Basic playback: rate_div=3, enable=1, one word 0x0004_0003_0002_0001. Expect sample_data 0x0001, 0x0002, 0x0003, 0x0004, strobes 4 cycles apart, then underflow=1 on the next tick; sample_count_sts=4.
- Full rate, continuous: rate_div=0, tvalid always high, 8 words. Expect 32 consecutive strobes with no gap, tready high once every 4 cycles, underflow=0.
- Backpressure source: rate_div=0, tvalid gaps of 2 cycles between words. Expect underflow set at the first starved tick and missing strobes there; underflow_clr clears it unless a starved tick occurs in the same cycle.
- Pause mid-word: disable after lane 1, wait 10 cycles, re-enable. Expect resumption at lane 2, first strobe rate_div+1 cycles after enable returns, no underflow.
- Reset mid-word: assert aresetn=0 asynchronously between clock edges. Expect all outputs at reset values immediately, tready=1, and the held word discarded.
- rate_div change: lower it from 100 to 2 while cnt=50. Expect a tick on the next cycle, then a 3-cycle period.
